// File: rtl/ttrng_pkg.sv
// Shared types and constants for the TTRNG debias/packer stage.
// Holds the pair-extractor state encoding and the health-counter width helper.
package ttrng_pkg;

    localparam int BYTE_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int REP_LIMIT_DEF   = 31;

    typedef enum logic [0:0] {
        PAIR_IDLE  = 1'b0,
        PAIR_FIRST = 1'b1
    } pair_state_e;

    // Width needed to hold a repetition count of 0..rep_limit.
    function automatic int run_len_w(input int rep_limit);
        return $clog2(rep_limit + 1);
    endfunction

endpackage

// File: rtl/ttrng_sync.sv
// Multi-flop synchroniser for the asynchronous raw entropy bit.
// The chain clears to 0 on reset, so the first synchronised samples read as 0.
module ttrng_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw bit through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {SYNC_STAGES{1'b0}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ttrng_debias_packer.sv
// Von Neumann debiaser, byte packer with valid/ack output buffer, and a
// repetition-count health test that blocks output once the raw stream sticks.
module ttrng_debias_packer
    import ttrng_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              raw_bit,
    input  logic              byte_ack,
    input  logic              clear_err,
    output logic [BYTE_W-1:0] data_out,
    output logic              byte_valid,
    output logic              health_fail,
    output logic              overrun
);

    localparam int RUN_W = run_len_w(REP_LIMIT);
    localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_W - 1);

    logic               w_raw_s;
    pair_state_e        r_state,   w_state_nxt;
    logic               r_b0,      w_b0_nxt;
    logic [BYTE_W-2:0]  r_shift,   w_shift_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_cnt_nxt;
    logic [BYTE_W-1:0]  r_data,    w_data_nxt;
    logic               r_valid,   w_valid_nxt;
    logic               r_fail,    w_fail_nxt;
    logic               r_overrun, w_ovr_nxt;
    logic [RUN_W-1:0]   r_run_len, w_run_nxt, w_run_step;
    logic               r_last,    w_last_nxt;
    logic               w_trip;
    logic [BYTE_W-1:0]  w_word;

    ttrng_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (raw_bit),
        .o_q   (w_raw_s)
    );

    assign w_word = {r_shift, r_b0};

    // Repetition counter step: a run of 0 means no reference sample yet.
    always_comb begin
        w_run_step = r_run_len;
        w_last_nxt = r_last;
        if (ena) begin
            w_last_nxt = w_raw_s;
            if ((r_run_len == {RUN_W{1'b0}}) || (w_raw_s != r_last)) begin
                w_run_step = RUN_W'(1);
            end else if (r_run_len != RUN_MAX) begin
                w_run_step = r_run_len + RUN_W'(1);
            end else begin
                w_run_step = r_run_len;
            end
        end else begin
            w_run_step = r_run_len;
        end
    end

    assign w_trip = ena && !r_fail && (w_run_step == RUN_MAX);

    // Next-state for the pair FSM, packer, output buffer and sticky flags.
    always_comb begin
        w_state_nxt = r_state;
        w_b0_nxt    = r_b0;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_fail_nxt  = r_fail;
        w_ovr_nxt   = r_overrun;
        w_run_nxt   = w_run_step;

        if (clear_err) begin
            // Clear wins over a simultaneous trip; a pending word survives.
            w_fail_nxt  = 1'b0;
            w_ovr_nxt   = 1'b0;
            w_run_nxt   = {RUN_W{1'b0}};
            w_state_nxt = PAIR_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_shift_nxt = {(BYTE_W-1){1'b0}};
            w_valid_nxt = r_valid && !byte_ack;
        end else if (w_trip) begin
            w_fail_nxt  = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = PAIR_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_shift_nxt = {(BYTE_W-1){1'b0}};
        end else begin
            if (r_valid && byte_ack) begin
                w_valid_nxt = 1'b0;
            end else begin
                w_valid_nxt = r_valid;
            end

            if (!ena || r_fail) begin
                w_state_nxt = PAIR_IDLE;
            end else begin
                case (r_state)
                    PAIR_IDLE: begin
                        w_b0_nxt    = w_raw_s;
                        w_state_nxt = PAIR_FIRST;
                    end
                    PAIR_FIRST: begin
                        w_state_nxt = PAIR_IDLE;
                        if (w_raw_s != r_b0) begin
                            w_shift_nxt = w_word[BYTE_W-2:0];
                            if (r_bit_cnt == CNT_LAST) begin
                                w_cnt_nxt = {CNT_W{1'b0}};
                                if (!r_valid || byte_ack) begin
                                    w_data_nxt  = w_word;
                                    w_valid_nxt = 1'b1;
                                end else begin
                                    w_ovr_nxt = 1'b1;
                                end
                            end else begin
                                w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                            end
                        end else begin
                            w_shift_nxt = r_shift;
                        end
                    end
                    default: begin
                        w_state_nxt = PAIR_IDLE;
                    end
                endcase
            end
        end
    end

    // State registers for all datapath and control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PAIR_IDLE;
            r_b0      <= 1'b0;
            r_shift   <= {(BYTE_W-1){1'b0}};
            r_bit_cnt <= {CNT_W{1'b0}};
            r_data    <= {BYTE_W{1'b0}};
            r_valid   <= 1'b0;
            r_fail    <= 1'b0;
            r_overrun <= 1'b0;
            r_run_len <= {RUN_W{1'b0}};
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_b0      <= w_b0_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_fail    <= w_fail_nxt;
            r_overrun <= w_ovr_nxt;
            r_run_len <= w_run_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign data_out    = r_data;
    assign byte_valid  = r_valid;
    assign health_fail = r_fail;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_ttrng_debias_packer.sv
// Scenario bench for ttrng_debias_packer: expected words queue up as raw pairs
// are driven and a negedge monitor pops them as the DUT presents new words.
module tb_ttrng_debias_packer;

    localparam int SYNC = 2;
    localparam int BW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          raw_bit = 1'b0;
    logic          byte_ack = 1'b0;
    logic          clear_err = 1'b0;
    logic [BW-1:0] data_out;
    logic          byte_valid;
    logic          health_fail;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [BW-1:0] exp_q[$];
    bit pat[$];
    logic mon_pv = 1'b0;
    logic mon_pa = 1'b0;

    ttrng_debias_packer #(.SYNC_STAGES(SYNC), .BYTE_W(BW), .REP_LIMIT(31)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit),
        .byte_ack(byte_ack), .clear_err(clear_err), .data_out(data_out),
        .byte_valid(byte_valid), .health_fail(health_fail), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Pop the scoreboard whenever a fresh word appears on the output.
    always @(negedge clk) begin
        logic [BW-1:0] e;
        if (byte_valid && (!mon_pv || mon_pa)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_word: got %02h, none expected", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_errors++;
                    $display("FAIL word: got %02h, expected %02h", data_out, e);
                end
            end
        end
        mon_pv = byte_valid;
        mon_pa = byte_valid && byte_ack;
    end

    // Encode a word as von Neumann pairs (MSB first), optionally with discarded pairs.
    task automatic add_word(input logic [BW-1:0] w, input bit junk, input int nbits);
        for (int i = BW - 1; i >= BW - nbits; i--) begin
            if (junk && i == 4) begin
                pat.push_back(1'b0); pat.push_back(1'b0);
                pat.push_back(1'b1); pat.push_back(1'b1);
            end
            pat.push_back(w[i]);
            pat.push_back(~w[i]);
        end
    endtask

    // Drive pat with ena aligned to the synchroniser delay; optional ack on the last sample.
    task automatic send_pat(input bit ack_last);
        int n;
        n = pat.size();
        for (int j = 0; j <= n + SYNC; j++) begin
            @(posedge clk); #1;
            raw_bit  = (j < n) ? pat[j] : 1'b0;
            ena      = (j >= SYNC) && (j < n + SYNC);
            byte_ack = ack_last && (j == n + SYNC - 1);
        end
        byte_ack = 1'b0;
        pat.delete();
    endtask

    task automatic pulse(input bit is_clear);
        @(posedge clk); #1;
        if (is_clear) clear_err = 1'b1; else byte_ack = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        byte_ack  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({byte_valid, health_fail, overrun, data_out} !== {3'b000, 8'h00}) begin
            n_errors++;
            $display("FAIL reset: got v=%b h=%b o=%b d=%02h, expected all 0",
                     byte_valid, health_fail, overrun, data_out);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        for (int k = 0; k < 8; k++) begin
            pat.push_back(1'b1); pat.push_back(1'b0);
        end
        exp_q.push_back(8'hFF);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'hFF) begin
            n_errors++;
            $display("FAIL ones_byte: got v=%b d=%02h, expected v=1 d=ff", byte_valid, data_out);
        end
        pulse(1'b0);
    endtask

    task automatic test_no_emit();
        for (int k = 0; k < 16; k++) begin
            pat.push_back(1'b0); pat.push_back(1'b0);
            pat.push_back(1'b1); pat.push_back(1'b1);
        end
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b0 || health_fail !== 1'b0) begin
            n_errors++;
            $display("FAIL equal_pairs: got v=%b h=%b, expected v=0 h=0", byte_valid, health_fail);
        end
    endtask

    task automatic test_back_to_back();
        add_word(8'hA5, 1'b0, 8);
        exp_q.push_back(8'hA5);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'hA5) begin
            n_errors++;
            $display("FAIL a5_byte: got v=%b d=%02h, expected v=1 d=a5", byte_valid, data_out);
        end
        add_word(8'h3E, 1'b1, 8);
        exp_q.push_back(8'h3E);
        send_pat(1'b1);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'h3E || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_same_cycle: got v=%b d=%02h o=%b, expected v=1 d=3e o=0",
                     byte_valid, data_out, overrun);
        end
        pulse(1'b0);
        n_checks++;
        if (byte_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_clears: got v=%b, expected 0", byte_valid);
        end
    endtask

    task automatic test_overrun();
        add_word(8'h5A, 1'b0, 8);
        add_word(8'hC3, 1'b0, 8);
        exp_q.push_back(8'h5A);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'h5A || overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun: got v=%b d=%02h o=%b, expected v=1 d=5a o=1",
                     byte_valid, data_out, overrun);
        end
        pulse(1'b1);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'h5A || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_overrun: got v=%b d=%02h o=%b, expected v=1 d=5a o=0",
                     byte_valid, data_out, overrun);
        end
    endtask

    task automatic test_health();
        for (int k = 0; k < 30; k++) pat.push_back(1'b1);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (health_fail !== 1'b0 || byte_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL run30: got h=%b v=%b, expected h=0 v=1", health_fail, byte_valid);
        end
        pat.push_back(1'b1);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (health_fail !== 1'b1 || byte_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL run31: got h=%b v=%b, expected h=1 v=0", health_fail, byte_valid);
        end
        add_word(8'hE7, 1'b0, 8);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (health_fail !== 1'b1 || byte_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL blocked: got h=%b v=%b, expected h=1 v=0", health_fail, byte_valid);
        end
        pulse(1'b1);
        n_checks++;
        if (health_fail !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_health: got h=%b, expected 0", health_fail);
        end
        add_word(8'h3C, 1'b0, 8);
        exp_q.push_back(8'h3C);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'h3C) begin
            n_errors++;
            $display("FAIL post_clear_byte: got v=%b d=%02h, expected v=1 d=3c", byte_valid, data_out);
        end
    endtask

    task automatic test_reset_mid_word();
        add_word(8'hD0, 1'b0, 5);
        send_pat(1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({byte_valid, health_fail, overrun, data_out} !== {3'b000, 8'h00}) begin
            n_errors++;
            $display("FAIL async_reset: got v=%b h=%b o=%b d=%02h, expected all 0",
                     byte_valid, health_fail, overrun, data_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        add_word(8'h96, 1'b0, 8);
        exp_q.push_back(8'h96);
        send_pat(1'b0);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b1 || data_out !== 8'h96 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL fresh_word: got v=%b d=%02h o=%b, expected v=1 d=96 o=0",
                     byte_valid, data_out, overrun);
        end
        pulse(1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_no_emit();
        test_back_to_back();
        test_overrun();
        test_health();
        test_reset_mid_word();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d words never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
